rng_byte_collector: RTL and testbench



---
 rtl/rng_byte_collector_if.sv | 16 +
 rtl/rng_byte_collector.sv | 163 ++++++++++++++++
 tb/tb_rng_byte_collector.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_byte_collector_if.sv
// Purpose: request/byte-delivery bundle between rng_byte_collector and its consumer.
// Latency: none; this file only groups the signals.
// Backpressure: 4-phase. The consumer holds req high until it has taken data_out, then drops req.
//
// Signals:
//   req      consumer -> collector  request a new byte (4-phase)
//   valid    collector -> consumer  data_out holds a completed byte
//   data_out collector -> consumer  last completed byte
interface rng_byte_collector_if;
  logic       req;
  logic       valid;
  logic [7:0] data_out;

  modport master (output req, input valid, input data_out);
  modport slave  (input req, output valid, output data_out);
endinterface

// File: rtl/rng_byte_collector.sv
// Purpose: packs LFSR nibbles (raw) or von Neumann bits into a byte, and flags a stuck source.
// Latency: with DEBIAS=0, valid is 3 cycles after req rises when en stays high.
//          With DEBIAS=1, the latency depends on the data and is at least 8 enabled COLLECT edges.
// Backpressure: 4-phase req/valid. The byte holds while req=1. A req drop during COLLECT discards the partial byte.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   rnd_in_i[3:0] LFSR nibble, sampled on edges where en_i=1
//   en_i          sample enable; while low, all datapath and health state holds
//   stuck_err_o   sticky flag: STUCK_LIMIT consecutive identical enabled samples
//   bus           slave side of rng_byte_collector_if (req in; valid and data_out out)
module rng_byte_collector #(
  parameter bit          DEBIAS      = 1'b1,
  parameter int unsigned STUCK_LIMIT = 8      // legal range 2..15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            rnd_in_i,
  input  logic                  en_i,
  output logic                  stuck_err_o,
  rng_byte_collector_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  localparam logic [3:0] LIMIT = 4'(STUCK_LIMIT);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] count_q, count_d;
  logic [7:0] data_q,  data_d;
  logic       valid_q, valid_d;
  logic       stuck_q, stuck_d;
  logic [3:0] prev_q,  prev_d;
  logic [3:0] run_q,   run_d;

  logic       stuck_set;
  logic [3:0] run_inc;
  logic [7:0] shift_nx;
  logic [3:0] count_nx;

  assign run_inc = run_q + 4'd1;

  // Health check. It runs in every FSM state, but only on enabled edges.
  // run_q counts repeats of the previous sample. The fault fires on the edge where that count reaches LIMIT.
  always_comb begin
    prev_d    = prev_q;
    run_d     = run_q;
    stuck_set = 1'b0;
    if (en_i) begin
      prev_d = rnd_in_i;
      if (rnd_in_i == prev_q) begin
        if (run_q != 4'hF) begin
          run_d = run_inc;
        end
        if (run_inc == LIMIT) begin
          stuck_set = 1'b1;
        end
      end else begin
        run_d = 4'd0;
      end
    end
  end

  assign stuck_d = stuck_q | stuck_set;

  // Candidate shift/count after one enabled COLLECT edge.
  // New data enters at the LSB, so the earliest sample ends up at the top of the byte.
  always_comb begin
    shift_nx = shift_q;
    count_nx = count_q;
    if (DEBIAS == 1'b0) begin
      shift_nx = (shift_q << 4) | {4'h0, rnd_in_i};
      count_nx = count_q + 4'd4;
    end else begin
      unique case (rnd_in_i[1:0])
        2'b10: begin
          shift_nx = (shift_q << 1) | 8'h01;
          count_nx = count_q + 4'd1;
        end
        2'b01: begin
          shift_nx = shift_q << 1;
          count_nx = count_q + 4'd1;
        end
        default: ;  // 00 and 11 carry no unbiased bit
      endcase
    end
  end

  // FSM. A fault, including one raised on this same edge, overrides completion and any request.
  // An abort (req low in COLLECT) likewise wins over a completion on the same edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (stuck_d) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      shift_d = 8'h00;
      count_d = 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          shift_d = 8'h00;
          count_d = 4'd0;
          if (bus.req) begin
            state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (!bus.req) begin
            state_d = S_IDLE;
          end else if (en_i) begin
            if (count_nx == 4'd8) begin
              data_d  = shift_nx;
              valid_d = 1'b1;
              state_d = S_HOLD;
            end else begin
              shift_d = shift_nx;
              count_d = count_nx;
            end
          end
        end
        S_HOLD: begin
          if (!bus.req) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= 8'h00;
      count_q <= 4'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
      prev_q  <= 4'h0;
      run_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
    end
  end

  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;
  assign stuck_err_o  = stuck_q;

endmodule

// File: tb/tb_rng_byte_collector.sv
// Bench for rng_byte_collector. It runs one raw-nibble instance and one debiasing instance on shared rnd/en.
// Expected bytes and timing come from transaction-level arithmetic on the stimulus that the bench generates.
module tb_rng_byte_collector;
  localparam int L = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] rnd;
  logic       en;
  logic       stuck0, stuck1;

  int checks = 0;
  int errors = 0;

  logic [3:0] last_nib;      // last nibble the DUTs sampled with en=1
  logic [7:0] exp_data0;     // last completed byte expected from each instance
  logic [7:0] exp_data1;
  logic [1:0] pq[$];         // pair list for a debiased transfer

  rng_byte_collector_if if0 ();
  rng_byte_collector_if if1 ();

  rng_byte_collector #(.DEBIAS(1'b0), .STUCK_LIMIT(L)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rnd_in_i(rnd), .en_i(en), .stuck_err_o(stuck0), .bus(if0)
  );
  rng_byte_collector #(.DEBIAS(1'b1), .STUCK_LIMIT(L)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rnd_in_i(rnd), .en_i(en), .stuck_err_o(stuck1), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle at a negedge. Outputs are then read at the next negedge.
  task automatic cyc(input logic [3:0] n, input logic e);
    rnd = n;
    en  = e;
    if (e) last_nib = n;
    @(negedge clk);
  endtask

  // Random nibble that differs from the last enabled sample and from 'avoid'.
  function automatic logic [3:0] fresh(input logic [3:0] avoid);
    logic [3:0] r;
    do r = 4'($urandom_range(0, 15)); while (r == last_nib || r == avoid);
    return r;
  endfunction

  // Nibble with the given low pair and a random upper half, never repeating the last sample.
  function automatic logic [3:0] nib_pair(input logic [1:0] p);
    logic [1:0] up;
    logic [3:0] n;
    up = 2'($urandom_range(0, 3));
    n  = {up, p};
    if (n == last_nib) n = {up + 2'd1, p};
    return n;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    if0.req = 1'b0;
    if1.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_nib = 4'h0;
    exp_data0 = 8'h00;
    exp_data1 = 8'h00;
  endtask

  // One raw-nibble transaction on instance 0, with 'stall' en=0 cycles between the nibbles.
  task automatic xfer0(input logic [3:0] n0, input logic [3:0] n1, input int stall);
    if0.req = 1'b1;
    cyc(fresh(n0), 1'b1);                       // req sampled in IDLE
    checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL x0_idle_valid: got %b want 0", if0.valid); end
    cyc(n0, 1'b1);
    checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL x0_half_valid: got %b want 0", if0.valid); end
    checks++; if (if0.data_out !== exp_data0) begin errors++; $display("FAIL x0_half_data: got %h want %h", if0.data_out, exp_data0); end
    for (int s = 0; s < stall; s++) begin
      cyc(4'($urandom_range(0, 15)), 1'b0);
      checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL x0_stall_valid: got %b want 0 (stall %0d)", if0.valid, s); end
    end
    cyc(n1, 1'b1);
    exp_data0 = {n0, n1};
    checks++; if (if0.valid !== 1'b1) begin errors++; $display("FAIL x0_done_valid: got %b want 1", if0.valid); end
    checks++; if (if0.data_out !== exp_data0) begin errors++; $display("FAIL x0_done_data: got %h want %h", if0.data_out, exp_data0); end
    for (int h = 0; h < 2; h++) begin
      cyc(fresh(last_nib), 1'b1);
      checks++; if (if0.valid !== 1'b1 || if0.data_out !== exp_data0) begin
        errors++; $display("FAIL x0_hold: got valid=%b data=%h want valid=1 data=%h", if0.valid, if0.data_out, exp_data0);
      end
    end
    if0.req = 1'b0;
    cyc(fresh(last_nib), 1'b1);
    checks++; if (if0.valid !== 1'b0 || if0.data_out !== exp_data0) begin
      errors++; $display("FAIL x0_release: got valid=%b data=%h want valid=0 data=%h", if0.valid, if0.data_out, exp_data0);
    end
  endtask

  // One debiased transaction on instance 1 using pq. Optionally inserts random stall cycles.
  task automatic xfer1(input bit allow_stall);
    logic [7:0] exp_b;
    int nbits;
    exp_b = 8'h00;
    nbits = 0;
    if1.req = 1'b1;
    cyc(fresh(last_nib), 1'b1);
    checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL x1_idle_valid: got %b want 0", if1.valid); end
    foreach (pq[i]) begin
      if (allow_stall && $urandom_range(0, 3) == 0) begin
        cyc(4'($urandom_range(0, 15)), 1'b0);
        checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL x1_stall_valid: got %b want 0", if1.valid); end
      end
      if (pq[i] == 2'b10 || pq[i] == 2'b01) begin
        if (pq[i] == 2'b10) exp_b = exp_b | (8'h80 >> nbits);
        nbits++;
      end
      cyc(nib_pair(pq[i]), 1'b1);
      if (nbits == 8) begin
        exp_data1 = exp_b;
        checks++; if (if1.valid !== 1'b1 || if1.data_out !== exp_data1) begin
          errors++; $display("FAIL x1_done: got valid=%b data=%h want valid=1 data=%h", if1.valid, if1.data_out, exp_data1);
        end
      end else begin
        checks++; if (if1.valid !== 1'b0) begin errors++; $display("FAIL x1_early_valid: got %b want 0 (pair %0d)", if1.valid, i); end
      end
    end
    cyc(fresh(last_nib), 1'b1);
    checks++; if (if1.valid !== 1'b1 || if1.data_out !== exp_data1) begin
      errors++; $display("FAIL x1_hold: got valid=%b data=%h want valid=1 data=%h", if1.valid, if1.data_out, exp_data1);
    end
    if1.req = 1'b0;
    cyc(fresh(last_nib), 1'b1);
    checks++; if (if1.valid !== 1'b0 || if1.data_out !== exp_data1) begin
      errors++; $display("FAIL x1_release: got valid=%b data=%h want valid=0 data=%h", if1.valid, if1.data_out, exp_data1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    rnd = 4'h0;
    if0.req = 1'b0;
    if1.req = 1'b0;
    @(negedge clk);
    checks++; if (if0.valid !== 1'b0 || if0.data_out !== 8'h00 || stuck0 !== 1'b0) begin
      errors++; $display("FAIL reset_dut0: got valid=%b data=%h stuck=%b want 0/00/0", if0.valid, if0.data_out, stuck0);
    end
    checks++; if (if1.valid !== 1'b0 || if1.data_out !== 8'h00 || stuck1 !== 1'b0) begin
      errors++; $display("FAIL reset_dut1: got valid=%b data=%h stuck=%b want 0/00/0", if1.valid, if1.data_out, stuck1);
    end
    do_reset();
  endtask

  task automatic test_debias0();
    logic [3:0] n0;
    xfer0(4'hA, 4'h5, 0);
    for (int i = 0; i < 4; i++) begin
      n0 = 4'($urandom_range(0, 15));
      xfer0(n0, n0 ^ 4'($urandom_range(1, 15)), 0);
    end
  endtask

  task automatic test_stall();
    logic [3:0] n0;
    for (int i = 0; i < 3; i++) begin
      n0 = 4'($urandom_range(0, 15));
      xfer0(n0, n0 ^ 4'($urandom_range(1, 15)), $urandom_range(1, 4));
    end
  endtask

  task automatic test_debias1();
    logic [1:0] p;
    int nb;
    pq = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    xfer1(1'b0);
    checks++; if (if1.data_out !== 8'hB2) begin errors++; $display("FAIL debias_fixed: got %h want b2", if1.data_out); end
    for (int t = 0; t < 4; t++) begin
      pq.delete();
      nb = 0;
      while (nb < 8) begin
        p = 2'($urandom_range(0, 3));
        if (pq.size() >= 30) p = 2'b10;
        pq.push_back(p);
        if (p == 2'b10 || p == 2'b01) nb++;
      end
      xfer1(t[0]);
    end
  endtask

  task automatic test_abort();
    xfer0(4'hA, 4'h5, 0);
    if0.req = 1'b1;
    cyc(fresh(4'h3), 1'b1);
    cyc(4'h3, 1'b1);
    checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL abort_partial_valid: got %b want 0", if0.valid); end
    if0.req = 1'b0;
    cyc(fresh(last_nib), 1'b1);  // this edge would otherwise complete the byte
    for (int i = 0; i < 3; i++) begin
      checks++; if (if0.valid !== 1'b0 || if0.data_out !== 8'hA5) begin
        errors++; $display("FAIL abort_hold: got valid=%b data=%h want valid=0 data=a5", if0.valid, if0.data_out);
      end
      cyc(fresh(last_nib), 1'b1);
    end
    xfer0(4'h6, 4'hC, 0);         // a clean restart must not see the discarded nibble
  endtask

  task automatic test_async_reset();
    xfer0(4'hA, 4'h5, 0);
    if0.req = 1'b1;
    cyc(fresh(4'h0), 1'b1);
    cyc(fresh(4'h0), 1'b1);       // mid-COLLECT
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if0.valid !== 1'b0 || if0.data_out !== 8'h00 || stuck0 !== 1'b0) begin
      errors++; $display("FAIL async_reset_dut0: got valid=%b data=%h stuck=%b want 0/00/0", if0.valid, if0.data_out, stuck0);
    end
    checks++; if (if1.data_out !== 8'h00 || stuck1 !== 1'b0) begin
      errors++; $display("FAIL async_reset_dut1: got data=%h stuck=%b want 00/0", if1.data_out, stuck1);
    end
    if0.req = 1'b0;
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_nib = 4'h0;
    exp_data0 = 8'h00;
    exp_data1 = 8'h00;
    xfer0(4'h9, 4'h1, 0);         // normal latency shows the FSM restarted from IDLE
  endtask

  task automatic test_stuck_vs_completion();
    logic [3:0] v;
    v = fresh(4'h0);
    if0.req = 1'b0;
    repeat (L - 2) cyc(v, 1'b1);
    if0.req = 1'b1;
    cyc(v, 1'b1);
    cyc(v, 1'b1);
    checks++; if (stuck0 !== 1'b0 || if0.valid !== 1'b0) begin
      errors++; $display("FAIL stuck_pre: got stuck=%b valid=%b want 0/0", stuck0, if0.valid);
    end
    cyc(v, 1'b1);                  // final nibble and the L-th repeat on the same edge
    checks++; if (stuck0 !== 1'b1 || stuck1 !== 1'b1) begin
      errors++; $display("FAIL stuck_set: got %b/%b want 1/1", stuck0, stuck1);
    end
    checks++; if (if0.valid !== 1'b0 || if0.data_out !== exp_data0) begin
      errors++; $display("FAIL stuck_beats_done: got valid=%b data=%h want valid=0 data=%h", if0.valid, if0.data_out, exp_data0);
    end
    if1.req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(fresh(last_nib), 1'b1);
      checks++; if (if0.valid !== 1'b0 || if1.valid !== 1'b0 || stuck0 !== 1'b1) begin
        errors++; $display("FAIL stuck_sticky: got valid0=%b valid1=%b stuck=%b want 0/0/1", if0.valid, if1.valid, stuck0);
      end
    end
    do_reset();
    checks++; if (stuck0 !== 1'b0 || stuck1 !== 1'b0) begin
      errors++; $display("FAIL stuck_clear: got %b/%b want 0/0", stuck0, stuck1);
    end
  endtask

  task automatic test_stuck_from_reset();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cyc(4'h0, 1'b1);
      checks++; if (stuck0 !== (i >= L)) begin
        errors++; $display("FAIL stuck_zero_edge%0d: got %b want %b", i, stuck0, (i >= L));
      end
    end
    if0.req = 1'b1;
    if1.req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(4'($urandom_range(0, 15)), 1'b1);
      checks++; if (if0.valid !== 1'b0 || if1.valid !== 1'b0) begin
        errors++; $display("FAIL stuck_req_ignored: got %b/%b want 0/0", if0.valid, if1.valid);
      end
    end
    do_reset();
    checks++; if (stuck0 !== 1'b0) begin errors++; $display("FAIL stuck_zero_clear: got %b want 0", stuck0); end
  endtask

  task automatic test_stuck_stall();
    logic [3:0] v;
    v = fresh(4'h0);
    cyc(v, 1'b1);
    repeat (L - 1) cyc(v, 1'b1);
    checks++; if (stuck0 !== 1'b0) begin errors++; $display("FAIL stall_health_pre: got %b want 0", stuck0); end
    for (int i = 0; i < 3; i++) begin
      cyc(v ^ 4'($urandom_range(1, 15)), 1'b0);
      checks++; if (stuck0 !== 1'b0) begin errors++; $display("FAIL stall_health_hold: got %b want 0", stuck0); end
    end
    cyc(v, 1'b1);
    checks++; if (stuck0 !== 1'b1) begin errors++; $display("FAIL stall_health_resume: got %b want 1", stuck0); end
    do_reset();
  endtask

  initial begin
    last_nib = 4'h0;
    exp_data0 = 8'h00;
    exp_data1 = 8'h00;
    test_reset();
    test_debias0();
    test_stall();
    test_debias1();
    test_abort();
    test_async_reset();
    test_stuck_vs_completion();
    test_stuck_from_reset();
    test_stuck_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
